instr_word_serializer: RTL

INSTR_WORD_SERIALIZER -- requirements
Module: instr_word_serializer

---
 rtl/instr_word_serializer_pkg.sv | 19 +
 rtl/instr_word_serializer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/instr_word_serializer_pkg.sv
// -----------------------------------------------------------------------------
// instr_word_serializer_pkg
// Shared fetch-side definitions for the instruction word serializer:
//   WORD_W          - width of every instruction / immediate word
//   IMM_BIT_DEFAULT - default position of the "immediate follows" flag
//   state_e         - serializer FSM states
// -----------------------------------------------------------------------------
package instr_word_serializer_pkg;

    localparam int WORD_W          = 16;
    localparam int IMM_BIT_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        EMIT_INSTR = 2'd1,
        EMIT_IMM   = 2'd2
    } state_e;

endpackage : instr_word_serializer_pkg

// File: rtl/instr_word_serializer.sv
// -----------------------------------------------------------------------------
// instr_word_serializer
// Takes one instruction (optionally followed by an immediate word) per input
// handshake and emits it as a stream of 16-bit words, each tagged with a
// running word address. One word per cycle, no bubbles between transactions.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - producer offers an instruction
//   in_ready   - instruction accepted this cycle when in_valid is also high
//   in_instr   - instruction word; bit IMM_BIT set means an immediate follows
//   in_imm     - immediate word, only captured when the flag is set
//   out_valid  - out_word / out_addr / out_is_imm are valid
//   out_ready  - consumer takes the presented word
//   out_word   - emitted word
//   out_addr   - word address of out_word (wraps silently)
//   out_is_imm - presented word is an immediate
// -----------------------------------------------------------------------------
module instr_word_serializer
    import instr_word_serializer_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int IMM_BIT = IMM_BIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_instr,
    input  logic [WORD_W-1:0] in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_is_imm
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e              state_reg, state_next;
    logic [WORD_W-1:0]   instr_reg;
    logic [WORD_W-1:0]   imm_reg;
    logic                has_imm_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic                accept;
    logic                out_fire;

    // Outputs and next state. in_ready is high whenever the word currently on
    // the output is the last one of its transaction and is leaving this cycle,
    // so a new instruction can land directly behind it.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_is_imm = 1'b0;
        out_word   = '0;

        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
            end
            EMIT_INSTR: begin
                out_valid = 1'b1;
                out_word  = instr_reg;
                in_ready  = !has_imm_reg && out_ready;
            end
            EMIT_IMM: begin
                out_valid  = 1'b1;
                out_is_imm = 1'b1;
                out_word   = imm_reg;
                in_ready   = out_ready;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase

        accept   = in_valid && in_ready;
        out_fire = out_valid && out_ready;

        case (state_reg)
            IDLE: begin
                if (accept) state_next = EMIT_INSTR;
            end
            EMIT_INSTR: begin
                if (out_ready) begin
                    if (has_imm_reg) state_next = EMIT_IMM;
                    else if (accept) state_next = EMIT_INSTR;
                    else             state_next = IDLE;
                end
            end
            EMIT_IMM: begin
                if (out_ready) state_next = accept ? EMIT_INSTR : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            instr_reg   <= '0;
            imm_reg     <= '0;
            has_imm_reg <= 1'b0;
            addr_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                instr_reg   <= in_instr;
                has_imm_reg <= in_instr[IMM_BIT];
                // The immediate input is don't-care without the flag.
                if (in_instr[IMM_BIT]) imm_reg <= in_imm;
            end
            if (out_fire) addr_reg <= addr_reg + ADDR_ONE;
        end
    end

    assign out_addr = addr_reg;

endmodule : instr_word_serializer
